// File: rtl/controle_display_bcd_if.sv
// Bus between the two requesters (processor output instruction, debug/switch
// path) and the shared binary-to-BCD converter.
//   req_a/dado_a, req_b/dado_b : level requests with their binary words
//   ack_a/ack_b                : one-cycle capture pulses back to each requester
//   ocupado                    : conversion in progress
//   pronto                     : one-cycle pulse, digitos just updated
//   digitos/origem             : last completed BCD result and its source (0=A, 1=B)
interface controle_display_bcd_if #(
  parameter int WIDTH  = 26,
  parameter int DIGITS = 8
);
  logic                  req_a;
  logic [WIDTH-1:0]      dado_a;
  logic                  req_b;
  logic [WIDTH-1:0]      dado_b;
  logic                  ack_a;
  logic                  ack_b;
  logic                  ocupado;
  logic                  pronto;
  logic [4*DIGITS-1:0]   digitos;
  logic                  origem;

  modport master (
    output req_a, dado_a, req_b, dado_b,
    input  ack_a, ack_b, ocupado, pronto, digitos, origem
  );

  modport slave (
    input  req_a, dado_a, req_b, dado_b,
    output ack_a, ack_b, ocupado, pronto, digitos, origem
  );
endinterface

// File: rtl/controle_display_bcd.sv
// Shares one iterative binary-to-BCD converter (shift-add-3, one bit per clock)
// between requester A and requester B with round-robin arbitration. The last
// completed result is held as packed BCD digits for the 7-segment drivers.
// Ports:
//   clock : system clock, rising edge
//   reset : asynchronous, active-high; clears all state
//   bus   : controle_display_bcd_if.slave (requests, acks, status, result)
module controle_display_bcd #(
  parameter int WIDTH  = 26,
  parameter int DIGITS = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  controle_display_bcd_if.slave bus
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] OCIOSO   = 2'd0;
  localparam logic [1:0] CONVERTE = 2'd1;
  localparam logic [1:0] FIM      = 2'd2;

  logic [1:0]          state;
  logic                ptr;
  logic [WIDTH-1:0]    sr;
  logic [4*DIGITS-1:0] bcd;
  logic [CNT_W-1:0]    cnt;
  logic                orig;
  logic                ack_a_r;
  logic                ack_b_r;
  logic                pronto_r;
  logic [4*DIGITS-1:0] digitos_r;
  logic                origem_r;

  logic                grant_a;
  logic                grant_b;
  logic [4*DIGITS-1:0] bcd_adj;

  // Add 3 to every digit >= 5 ahead of the shift; 9+3=12 never overflows a nibble.
  function automatic logic [4*DIGITS-1:0] ajusta(input logic [4*DIGITS-1:0] v);
    logic [4*DIGITS-1:0] r;
    r = v;
    for (int k = 0; k < DIGITS; k++) begin
      if (v[4*k +: 4] >= 4'd5)
        r[4*k +: 4] = v[4*k +: 4] + 4'd3;
    end
    return r;
  endfunction

  // A lone requester always wins; under contention the pointer decides (0 -> A).
  assign grant_a = bus.req_a & (~bus.req_b | ~ptr);
  assign grant_b = bus.req_b & (~bus.req_a |  ptr);
  assign bcd_adj = ajusta(bcd);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= OCIOSO;
      ptr       <= 1'b0;
      sr        <= '0;
      bcd       <= '0;
      cnt       <= '0;
      orig      <= 1'b0;
      ack_a_r   <= 1'b0;
      ack_b_r   <= 1'b0;
      pronto_r  <= 1'b0;
      digitos_r <= '0;
      origem_r  <= 1'b0;
    end else begin
      ack_a_r  <= 1'b0;
      ack_b_r  <= 1'b0;
      pronto_r <= 1'b0;
      case (state)
        OCIOSO: begin
          if (grant_a || grant_b) begin
            sr      <= grant_b ? bus.dado_b : bus.dado_a;
            bcd     <= '0;
            cnt     <= CNT_W'(WIDTH - 1);
            orig    <= grant_b;
            ptr     <= ~grant_b;
            ack_a_r <= grant_a;
            ack_b_r <= grant_b;
            state   <= CONVERTE;
          end
        end
        CONVERTE: begin
          bcd <= {bcd_adj[4*DIGITS-2:0], sr[WIDTH-1]};
          sr  <= {sr[WIDTH-2:0], 1'b0};
          cnt <= cnt - 1'b1;
          if (cnt == '0)
            state <= FIM;
        end
        FIM: begin
          digitos_r <= bcd;
          origem_r  <= orig;
          pronto_r  <= 1'b1;
          state     <= OCIOSO;
        end
        default: state <= OCIOSO;
      endcase
    end
  end

  assign bus.ack_a   = ack_a_r;
  assign bus.ack_b   = ack_b_r;
  assign bus.pronto  = pronto_r;
  assign bus.digitos = digitos_r;
  assign bus.origem  = origem_r;
  assign bus.ocupado = (state != OCIOSO);

endmodule

// File: tb/tb_controle_display_bcd.sv
// Directed bench for controle_display_bcd: reset behaviour, single
// conversions from A and B, boundary values, round-robin under contention,
// reset mid-conversion and display stability during a conversion.
module tb_controle_display_bcd;

  logic clock;
  logic reset;
  int   npass;
  int   ntot;

  controle_display_bcd_if #(.WIDTH(26), .DIGITS(8)) bus ();

  controle_display_bcd #(.WIDTH(26), .DIGITS(8)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    ntot++;
    if (got === exp) npass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic chk_zero(input string pfx);
    chk({pfx, "_ack_a"},   bus.ack_a,   0);
    chk({pfx, "_ack_b"},   bus.ack_b,   0);
    chk({pfx, "_pronto"},  bus.pronto,  0);
    chk({pfx, "_ocupado"}, bus.ocupado, 0);
    chk({pfx, "_digitos"}, bus.digitos, 0);
    chk({pfx, "_origem"},  bus.origem,  0);
  endtask

  // One full conversion from a single requester, checked cycle by cycle.
  task automatic do_conv(input logic src, input logic [25:0] val,
                         input logic [31:0] exp, input logic [31:0] prev);
    int n;
    int busy;
    int extra;
    int unstable;
    @(negedge clock);
    if (src) begin bus.req_b = 1'b1; bus.dado_b = val; end
    else     begin bus.req_a = 1'b1; bus.dado_a = val; end
    n = 0;
    do begin
      @(posedge clock); #1; n++;
    end while (!(src ? bus.ack_b : bus.ack_a) && n < 5);
    chk("ack", src ? bus.ack_b : bus.ack_a, 1);
    chk("ack_latency", n, 1);
    chk("ack_other", src ? bus.ack_a : bus.ack_b, 0);
    if (src) bus.req_b = 1'b0; else bus.req_a = 1'b0;
    busy = 0; extra = 0; unstable = 0; n = 0;
    while (!bus.pronto && n < 40) begin
      if (bus.ocupado) busy++;
      if (n > 0 && (bus.ack_a || bus.ack_b)) extra++;
      if (bus.digitos !== prev) unstable++;
      @(posedge clock); #1; n++;
    end
    chk("pronto", bus.pronto, 1);
    chk("latency", n, 27);
    chk("ocupado_cycles", busy, 27);
    chk("ack_once", extra, 0);
    chk("display_stable", unstable, 0);
    chk("digitos", bus.digitos, exp);
    chk("origem", bus.origem, src);
    chk("ocupado_in_pronto", bus.ocupado, 0);
    @(posedge clock); #1;
    chk("pronto_pulse", bus.pronto, 0);
  endtask

  initial begin
    logic [2:0] ord;
    logic       who;
    int         n;
    int         pcount;
    npass = 0; ntot = 0;
    bus.req_a = 1'b0; bus.req_b = 1'b0;
    bus.dado_a = '0;  bus.dado_b = '0;
    reset = 1'b0;

    // Asynchronous reset between edges: outputs clear before any clock edge.
    #2 reset = 1'b1;
    #1 chk_zero("rst_async");
    repeat (3) @(posedge clock);
    @(negedge clock) reset = 1'b0;
    repeat (4) @(posedge clock);
    #1 chk_zero("rst_idle");

    // Single A request, then boundary values from B.
    do_conv(1'b0, 26'd12345678, 32'h12345678, 32'h0);
    do_conv(1'b1, 26'd67108863, 32'h67108863, 32'h12345678);
    do_conv(1'b1, 26'd0,        32'h00000000, 32'h67108863);
    do_conv(1'b1, 26'd9,        32'h00000009, 32'h00000000);

    // Round-robin under contention: expect A, B, A.
    @(negedge clock) reset = 1'b1;
    @(negedge clock) reset = 1'b0;
    ord = 3'b010;
    bus.dado_a = 26'd111; bus.dado_b = 26'd222;
    bus.req_a = 1'b1;     bus.req_b = 1'b1;
    for (int k = 0; k < 3; k++) begin
      n = 0;
      do begin
        @(posedge clock); #1; n++;
      end while (!(bus.ack_a || bus.ack_b) && n < 10);
      chk("rr_ack_seen", bus.ack_a | bus.ack_b, 1);
      who = bus.ack_b;
      chk("rr_grant", who, ord[k]);
      if (who) bus.req_b = 1'b0; else bus.req_a = 1'b0;
      @(negedge clock);
      if (who) bus.req_b = 1'b1; else bus.req_a = 1'b1;
      n = 0;
      while (!bus.pronto && n < 40) begin
        @(posedge clock); #1; n++;
      end
      if (k == 2) begin bus.req_a = 1'b0; bus.req_b = 1'b0; end
      chk("rr_pronto", bus.pronto, 1);
      chk("rr_origem", bus.origem, ord[k]);
      chk("rr_digitos", bus.digitos, ord[k] ? 32'h222 : 32'h111);
    end
    repeat (2) @(posedge clock);
    #1 chk("rr_idle", bus.ocupado, 0);

    // Reset in the middle of a conversion of 999 from A.
    @(negedge clock);
    bus.req_a = 1'b1; bus.dado_a = 26'd999;
    n = 0;
    do begin
      @(posedge clock); #1; n++;
    end while (!bus.ack_a && n < 5);
    chk("mid_ack", bus.ack_a, 1);
    bus.req_a = 1'b0;
    repeat (10) @(posedge clock);
    #3 reset = 1'b1;
    #1 chk_zero("mid_rst");
    @(negedge clock) reset = 1'b0;
    pcount = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clock); #1;
      if (bus.pronto) pcount++;
    end
    chk("mid_no_pronto", pcount, 0);
    chk("mid_digitos", bus.digitos, 0);
    do_conv(1'b1, 26'd42, 32'h00000042, 32'h0);

    // Display stability: 0x123 shown until 777 completes.
    do_conv(1'b0, 26'd123, 32'h00000123, 32'h00000042);
    do_conv(1'b0, 26'd777, 32'h00000777, 32'h00000123);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
